// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer-width derivation for the synchronous FIFO.
package sync_fifo_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 16;

    // One extra pointer bit beyond the address distinguishes full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_W register-array storage: one write port, one read port with
// both a registered (load-on-read) and a combinational read output.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_wr_en,
    input  logic [ptr_w(DEPTH)-2:0]   i_wr_addr,
    input  logic [DATA_W-1:0]         i_wr_data,
    input  logic                      i_rd_en,
    input  logic [ptr_w(DEPTH)-2:0]   i_rd_addr,
    output logic [DATA_W-1:0]         o_rd_data_q,
    output logic [DATA_W-1:0]         o_rd_data_c
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data_p1;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read register clears on reset; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data_p1 <= '0;
        end else if (i_rd_en) begin
            r_rd_data_p1 <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data_q = r_rd_data_p1;
    assign o_rd_data_c = r_mem[i_rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO with registered flags/count and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read behaviour.
module param_sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fifo_wr_en,
    input  logic [DATA_W-1:0]       fifo_wr_data,
    output logic                    fifo_full,
    output logic                    fifo_almost_full,
    output logic                    fifo_wr_err,
    input  logic                    fifo_rd_en,
    output logic [DATA_W-1:0]       fifo_rd_data,
    output logic                    fifo_rd_valid,
    output logic                    fifo_empty,
    output logic                    fifo_almost_empty,
    output logic                    fifo_rd_err,
    output logic [ptr_w(DEPTH)-1:0] fifo_count
);

    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int ADDR_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] AF_C = PTR_W'(AF_LVL);
    localparam logic [PTR_W-1:0] AE_C = PTR_W'(AE_LVL);

    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr, r_count;
    logic              r_full, r_empty, r_af, r_ae, r_wr_err, r_rd_err;
    logic              w_wr_acc, w_rd_acc, w_full_nxt;
    logic [PTR_W-1:0]  w_wr_ptr_nxt, w_rd_ptr_nxt, w_count_nxt;
    logic [DATA_W-1:0] w_rd_data_q, w_rd_data_c;

    // Requests are ignored while reset is high.
    assign w_wr_acc = fifo_wr_en & ~r_full  & ~rst;
    assign w_rd_acc = fifo_rd_en & ~r_empty & ~rst;

    assign w_wr_ptr_nxt = r_wr_ptr + {{(PTR_W-1){1'b0}}, w_wr_acc};
    assign w_rd_ptr_nxt = r_rd_ptr + {{(PTR_W-1){1'b0}}, w_rd_acc};
    assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_full_nxt   = (w_wr_ptr_nxt[PTR_W-1] != w_rd_ptr_nxt[PTR_W-1]) &&
                          (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_full   <= w_full_nxt;
            r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_af     <= (w_count_nxt >= AF_C);
            r_ae     <= (w_count_nxt <= AE_C);
            r_wr_err <= fifo_wr_en & r_full;
            r_rd_err <= fifo_rd_en & r_empty;
        end
    end

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (w_wr_acc),
        .i_wr_addr   (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data   (fifo_wr_data),
        .i_rd_en     (w_rd_acc),
        .i_rd_addr   (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data_q (w_rd_data_q),
        .o_rd_data_c (w_rd_data_c)
    );

`ifdef SYNC_FIFO_FWFT_EN
    logic w_unused_rd_q;
    assign w_unused_rd_q = ^w_rd_data_q;
    assign fifo_rd_data  = w_rd_data_c;
    assign fifo_rd_valid = ~r_empty;
`else
    logic r_rd_vld_p1;
    logic w_unused_rd_c;

    // Valid follows the accepted read by one cycle, alongside the read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld_p1 <= 1'b0;
        end else begin
            r_rd_vld_p1 <= w_rd_acc;
        end
    end

    assign w_unused_rd_c = ^w_rd_data_c;
    assign fifo_rd_data  = w_rd_data_q;
    assign fifo_rd_valid = r_rd_vld_p1;
`endif

    assign fifo_full         = r_full;
    assign fifo_almost_full  = r_af;
    assign fifo_empty        = r_empty;
    assign fifo_almost_empty = r_ae;
    assign fifo_wr_err       = r_wr_err;
    assign fifo_rd_err       = r_rd_err;
    assign fifo_count        = r_count;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo against a queue-based reference model.
// Honours SYNC_FIFO_FWFT_EN to match the DUT build.
module tb_param_sync_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_wr_en, fifo_rd_en;
    logic [DW-1:0] fifo_wr_data;
    logic          fifo_full, fifo_almost_full, fifo_wr_err;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_valid, fifo_empty, fifo_almost_empty, fifo_rd_err;
    logic [4:0]    fifo_count;

    param_sync_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .AF_LVL (AF),
        .AE_LVL (AE)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .fifo_wr_en        (fifo_wr_en),
        .fifo_wr_data      (fifo_wr_data),
        .fifo_full         (fifo_full),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_wr_err       (fifo_wr_err),
        .fifo_rd_en        (fifo_rd_en),
        .fifo_rd_data      (fifo_rd_data),
        .fifo_rd_valid     (fifo_rd_valid),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_rd_err       (fifo_rd_err),
        .fifo_count        (fifo_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] exp_hold;
    logic          exp_vld, exp_wr_err, exp_rd_err;
    bit            armed = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Apply one cycle of stimulus and advance the reference model at the edge.
    task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        int pre;
        logic [DW-1:0] v;
        rst = r; fifo_wr_en = w; fifo_rd_en = rd; fifo_wr_data = d;
        @(posedge clk);
        if (r) begin
            model_q.delete();
            sb_q.delete();
            exp_hold = '0; exp_vld = 1'b0; exp_wr_err = 1'b0; exp_rd_err = 1'b0;
        end else begin
            pre        = model_q.size();
            exp_wr_err = w && (pre == DEPTH);
            exp_rd_err = rd && (pre == 0);
            exp_vld    = rd && (pre > 0);
            if (rd && pre > 0) begin
                v = model_q.pop_front();
                sb_q.push_back(v);
                exp_hold = v;
            end
            if (w && pre < DEPTH) model_q.push_back(d);
        end
        armed = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        int sz;
        logic [DW-1:0] e;
        if (armed) begin
            sz = model_q.size();
            check("count",        32'(fifo_count),        32'(sz));
            check("full",         32'(fifo_full),         32'(sz == DEPTH));
            check("empty",        32'(fifo_empty),        32'(sz == 0));
            check("almost_full",  32'(fifo_almost_full),  32'(sz >= AF));
            check("almost_empty", 32'(fifo_almost_empty), 32'(sz <= AE));
            check("wr_err",       32'(fifo_wr_err),       32'(exp_wr_err));
            check("rd_err",       32'(fifo_rd_err),       32'(exp_rd_err));
`ifdef SYNC_FIFO_FWFT_EN
            check("rd_valid", 32'(fifo_rd_valid), 32'(sz != 0));
            if (sz != 0) check("fwft_head", 32'(fifo_rd_data), 32'(model_q[0]));
`else
            check("rd_valid", 32'(fifo_rd_valid), 32'(exp_vld));
            if (fifo_rd_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected at %0t: got data %0h expected no read", $time, fifo_rd_data);
                end else begin
                    e = sb_q.pop_front();
                    check("rd_data", 32'(fifo_rd_data), 32'(e));
                end
            end else begin
                check("rd_hold", 32'(fifo_rd_data), 32'(exp_hold));
            end
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; fifo_wr_en = 1'b0; fifo_rd_en = 1'b0; fifo_wr_data = '0;
        @(negedge clk);
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        // Fill with 1..16, then one rejected write while full.
        for (int i = 1; i <= DEPTH; i++) step(0, 1, 0, DW'(i));
        step(0, 1, 0, 16'hDEAD);
        step(0, 0, 0, '0);
        // Drain, then one rejected read while empty.
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, '0);
        step(0, 0, 1, '0);
        step(0, 0, 0, '0);
        // Steady state at count 5 across pointer wrap.
        for (int i = 0; i < 5; i++) step(0, 1, 0, DW'($urandom));
        for (int i = 0; i < 40; i++) step(0, 1, 1, DW'($urandom));
        // Reset at count 9 with requests held high.
        for (int i = 0; i < 4; i++) step(0, 1, 0, DW'($urandom));
        step(1, 1, 1, 16'hBEEF);
        for (int i = 0; i < 3; i++) step(0, 1, 0, DW'(16'h100 + i));
        for (int i = 0; i < 4; i++) step(0, 0, 1, '0);
        // Random traffic with shifting write/read bias to hit both extremes.
        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = ((i / 50) % 2 == 0) ? 75 : 25;
            step(0, $urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp), DW'($urandom));
        end
        step(0, 0, 0, '0);
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
